// File: rtl/seg_cathode_scanner_pkg.sv
// Shared widths, blank pattern and hex-to-segment decode for the cathode scanner.
// Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
package seg_cathode_scanner_pkg;

    localparam int DATA_W = 8;
    localparam int SEG_W  = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] hex);
        logic [SEG_W-1:0] pat;
        case (hex)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_cathode_scanner_hex_to_seg7.sv
// Combinational 4-bit hex digit to active-low 7-segment pattern.
module hex_to_seg7
    import seg_cathode_scanner_pkg::*;
(
    input  logic [3:0]       hex_i,
    output logic [SEG_W-1:0] seg_n_o
);

    // Pure table lookup
    always_comb begin
        seg_n_o = seg_decode(hex_i);
    end

endmodule

// File: rtl/seg_cathode_scanner.sv
// Two-digit cathode driver: pending slot, frame-boundary commit, pattern registers, output mux, err flag.
// Optional LEADING_ZERO_BLANK_EN blanks digit1 when its nibble is zero.
module seg_cathode_scanner
    import seg_cathode_scanner_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              an0_n,
    input  logic              an1_n,
    output logic [SEG_W-1:0]  seg_n,
    output logic              err
);

    logic              an1_q;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic [SEG_W-1:0]  pat0_q, pat0_d, pat1_q, pat1_d;
    logic              disp_valid_q, disp_valid_d;
    logic              err_q, err_d;
    logic              commit_s, accept_s;
    logic [SEG_W-1:0]  dec0_s, dec1_s, dig1_pat_s;

    hex_to_seg7 u_dec0 (.hex_i(pend_q[3:0]), .seg_n_o(dec0_s));
    hex_to_seg7 u_dec1 (.hex_i(pend_q[7:4]), .seg_n_o(dec1_s));

`ifdef LEADING_ZERO_BLANK_EN
    assign dig1_pat_s = (pend_q[7:4] == 4'h0) ? SEG_BLANK : dec1_s;
`else
    assign dig1_pat_s = dec1_s;
`endif

    // Frame boundary is the rising edge of an1_n; a commit frees the slot in the same cycle
    assign commit_s = ~an1_q & an1_n;
    assign in_ready = ~pend_full_q | commit_s;
    assign accept_s = in_valid & in_ready;

    // Next-state for pending slot, display patterns and error flag
    always_comb begin
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        pat0_d       = pat0_q;
        pat1_d       = pat1_q;
        disp_valid_d = disp_valid_q;
        err_d        = err_q | (~an0_n & ~an1_n);
        if (commit_s && pend_full_q) begin
            pat0_d       = dec0_s;
            pat1_d       = dig1_pat_s;
            disp_valid_d = 1'b1;
        end else begin
            disp_valid_d = disp_valid_q;
        end
        if (accept_s) begin
            pend_d      = in_data;
            pend_full_d = 1'b1;
        end else if (commit_s) begin
            pend_full_d = 1'b0;
        end else begin
            pend_full_d = pend_full_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an1_q        <= 1'b1;
            pend_q       <= 8'h00;
            pend_full_q  <= 1'b0;
            pat0_q       <= SEG_BLANK;
            pat1_q       <= SEG_BLANK;
            disp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            an1_q        <= an1_n;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            pat0_q       <= pat0_d;
            pat1_q       <= pat1_d;
            disp_valid_q <= disp_valid_d;
            err_q        <= err_d;
        end
    end

    // Output mux of registered patterns; overlapping or idle strobes stay blank
    always_comb begin
        seg_n = SEG_BLANK;
        if (disp_valid_q && !an0_n && an1_n) begin
            seg_n = pat0_q;
        end else if (disp_valid_q && !an1_n && an0_n) begin
            seg_n = pat1_q;
        end else begin
            seg_n = SEG_BLANK;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_seg_cathode_scanner.sv
// Bench for seg_cathode_scanner with an upstream 5-bit down-counter anode driver and a value-level model.
module tb_seg_cathode_scanner;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       an0_n, an1_n;
    logic [6:0] seg_n;
    logic       err;

    int total = 0;
    int bad   = 0;

    logic [4:0] cnt;
    logic       force_both;

    logic [6:0] lut [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: the value waiting, the value on show, and the sticky error
    logic [7:0] m_pend, m_shown;
    bit         m_full, m_has, m_err, m_an1_prev;

    always #5 clk = ~clk;

    seg_cathode_scanner dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .an0_n(an0_n), .an1_n(an1_n), .seg_n(seg_n), .err(err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 8'h00; m_shown = 8'h00;
        m_full = 0; m_has = 0; m_err = 0; m_an1_prev = 1;
    endtask

    function automatic logic [6:0] exp_seg();
        logic [3:0] d1;
        d1 = m_shown[7:4];
        if (m_has && !an0_n && an1_n) return lut[m_shown[3:0]];
        if (m_has && !an1_n && an0_n) return (LZB && d1 == 4'h0) ? 7'h7F : lut[d1];
        return 7'h7F;
    endfunction

    function automatic logic exp_ready();
        return !m_full || (!m_an1_prev && an1_n);
    endfunction

    task automatic model_step();
        bit frame_edge, rdy;
        frame_edge = !m_an1_prev && an1_n;
        rdy = exp_ready();
        if (frame_edge && m_full) begin
            m_shown = m_pend;
            m_has   = 1;
        end
        if (in_valid && rdy) begin
            m_pend = in_data;
            m_full = 1;
        end else if (frame_edge) begin
            m_full = 0;
        end
        if (!an0_n && !an1_n) m_err = 1;
        m_an1_prev = an1_n;
    endtask

    task automatic drive_anodes();
        an0_n = force_both ? 1'b0 : ~cnt[4];
        an1_n = force_both ? 1'b0 : cnt[4];
    endtask

    // One clock: check outputs against the model, then advance model and upstream driver
    task automatic cycle();
        @(negedge clk);
        check_eq("seg", seg_n, exp_seg());
        check_eq("rdy", in_ready, exp_ready());
        check_eq("err", err, m_err);
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        cnt = cnt - 5'd1;
        drive_anodes();
    endtask

    task automatic cycle_x(input string tag, input logic [6:0] want);
        @(negedge clk);
        check_eq(tag, seg_n, want);
        #0;
        cycle_body();
    endtask

    task automatic cycle_body();
        check_eq("seg", seg_n, exp_seg());
        check_eq("rdy", in_ready, exp_ready());
        check_eq("err", err, m_err);
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        cnt = cnt - 5'd1;
        drive_anodes();
    endtask

    task automatic run_to(input logic [4:0] v);
        for (int i = 0; i < 40 && cnt != v; i++) cycle();
    endtask

    task automatic push_one(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        cnt = 5'd31; force_both = 1'b0;
        drive_anodes();
        model_reset();
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b0;

        // Idle frames: blank, ready, no error
        for (int i = 0; i < 96; i++) cycle();

        // 0x3A mid-frame shows from the next frame only
        run_to(5'd20);
        push_one(8'h3A);
        run_to(5'd8);
        cycle_x("3a_old", 7'h7F);
        run_to(5'd24);
        cycle_x("3a_d0", 7'h08);
        run_to(5'd8);
        cycle_x("3a_d1", 7'h30);

        // 0x12 then held 0x80: stalls until the commit cycle
        run_to(5'd20);
        push_one(8'h12);
        in_valid = 1'b1;
        in_data  = 8'h80;
        for (int i = 0; i < 40 && cnt != 5'd31; i++) cycle();
        cycle();
        in_valid = 1'b0;
        run_to(5'd24);
        cycle_x("12_d0", 7'h24);
        run_to(5'd8);
        cycle_x("12_d1", 7'h79);
        run_to(5'd24);
        cycle_x("80_d0", 7'h40);
        run_to(5'd8);
        cycle_x("80_d1", 7'h00);

        // Every nibble through the decoder
        for (int k = 0; k < 8; k++) begin
            run_to(5'd20);
            push_one({4'(2*k+1), 4'(2*k)});
        end
        run_to(5'd20);
        run_to(5'd0);

        // Both anodes low for one cycle
        run_to(5'd24);
        force_both = 1'b1;
        drive_anodes();
        cycle_x("both_low", 7'h7F);
        force_both = 1'b0;
        drive_anodes();
        for (int i = 0; i < 40; i++) cycle();
        check_eq("err_sticky", err, 1'b1);

        // Reset before the commit discards the pending value
        run_to(5'd20);
        push_one(8'h55);
        cycle();
        reset = 1'b1;
        model_reset();
        cycle_x("rst_blank", 7'h7F);
        cycle();
        reset = 1'b0;
        run_to(5'd24);
        cycle_x("rst_d0", 7'h7F);
        run_to(5'd8);
        cycle_x("rst_d1", 7'h7F);

        // Leading zero on digit1
        run_to(5'd20);
        push_one(8'h05);
        run_to(5'd24);
        cycle_x("05_d0", 7'h12);
        run_to(5'd8);
        cycle_x("05_d1", LZB ? 7'h7F : 7'h40);

        // Random traffic with occasional strobe overlap and reset
        for (int i = 0; i < 2500; i++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                force_both = 1'b1;
                drive_anodes();
            end
            if ($urandom_range(0, 799) == 0) begin
                reset = 1'b1;
                model_reset();
            end
            cycle();
            reset = 1'b0;
            if (force_both) begin
                force_both = 1'b0;
                drive_anodes();
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 64; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
